// File: rtl/fc_input_buffer.sv
// Serial-to-parallel activation loader: assembles IN stream beats into the
// parallel vector x feeding the fully-connected layer, checking frame length.
module fc_input_buffer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [WIDTH-1:0] x [0:IN-1],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [WIDTH-1:0] x_r [0:IN-1];
    logic             s_ready_r;
    logic             x_valid_r;
    logic             frame_err_r;
    logic [15:0]      frame_cnt_r;
    logic             beat_s;
    logic             wr_en_s;
    logic             err_nxt_s;
    logic             cnt_inc_s;

    // s_ready_r mirrors the current state, so this is purely a registered decode
    assign beat_s = s_valid & s_ready_r;

    // Next-state, beat index and event decode
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        wr_en_s     = 1'b0;
        err_nxt_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_r)
            FILL: begin
                if (beat_s) begin
                    wr_en_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        idx_nxt_s = '0;
                        if (s_last) begin
                            state_nxt_s = HOLD;
                        end else begin
                            err_nxt_s   = 1'b1;
                            state_nxt_s = DRAIN;
                        end
                    end else begin
                        if (s_last) begin
                            err_nxt_s = 1'b1;
                            idx_nxt_s = '0;
                        end else begin
                            idx_nxt_s = idx_r + IDX_W'(1);
                        end
                    end
                end else begin
                    state_nxt_s = FILL;
                end
            end
            HOLD: begin
                if (x_ready) begin
                    cnt_inc_s   = 1'b1;
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            DRAIN: begin
                // Overlong frame: swallow beats until the producer's own last
                if (beat_s && s_last) begin
                    state_nxt_s = FILL;
                    idx_nxt_s   = '0;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = FILL;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // Control state and registered output decodes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= FILL;
            idx_r       <= '0;
            s_ready_r   <= 1'b1;
            x_valid_r   <= 1'b0;
            frame_err_r <= 1'b0;
            frame_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            s_ready_r   <= (state_nxt_s != HOLD);
            x_valid_r   <= (state_nxt_s == HOLD);
            frame_err_r <= err_nxt_s;
            if (cnt_inc_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
        end
    end

    // Activation vector storage; written only while filling
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                x_r[i] <= '0;
            end
        end else if (wr_en_s) begin
            x_r[idx_r] <= s_data;
        end
    end

    assign x         = x_r;
    assign s_ready   = s_ready_r;
    assign x_valid   = x_valid_r;
    assign frame_err = frame_err_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_fc_input_buffer.sv
// Directed self-checking bench for fc_input_buffer (WIDTH=8, IN=128).
module tb_fc_input_buffer;

    localparam int WIDTH = 8;
    localparam int IN    = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [WIDTH-1:0] x [0:IN-1];
    logic             x_valid;
    logic             x_ready;
    logic             frame_err;
    logic [15:0]      frame_cnt;

    int tests   = 0;
    int fails   = 0;
    int cyc     = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int c0;
    int e0;

    fc_input_buffer #(.WIDTH(WIDTH), .IN(IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [7:0] base);
        int bad;
        int first;
        logic [7:0] e;
        bad = 0;
        first = -1;
        for (int i = 0; i < IN; i++) begin
            e = 8'(base + i);
            if (x[i] !== e) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        tests++;
        assert (bad === 0) else begin
            fails++;
            e = 8'(base + first);
            $error("FAIL %s: %0d bad elements, x[%0d] observed %0h expected %0h",
                   tag, bad, first, x[first], e);
        end
    endtask

    task automatic send_frame(input logic [7:0] base, input int n, input int last_at, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                s_valid = 1'b0;
                s_last  = 1'b1;
                s_data  = 8'hFF;
                tick();
            end
            s_valid = 1'b1;
            s_data  = 8'(base + i);
            s_last  = (i == last_at);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic release_x();
        x_ready = 1'b1;
        tick();
        x_ready = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_data  = 8'h00;
        s_valid = 1'b0;
        s_last  = 1'b0;
        x_ready = 1'b0;
        tick();
        tick();
        chk("rst_x_valid", {31'd0, x_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_x127", {24'd0, x[127]}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Nominal frame with a slow consumer
        send_frame(8'h00, IN, IN - 1, 1'b0);
        chk("nom_x_valid", {31'd0, x_valid}, 32'd1);
        chk("nom_s_ready", {31'd0, s_ready}, 32'd0);
        check_vec("nom_vec", 8'h00);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        for (int k = 0; k < 10; k++) tick();
        s_valid = 1'b0;
        chk("nom_hold_valid", {31'd0, x_valid}, 32'd1);
        check_vec("nom_hold_vec", 8'h00);
        chk("nom_hold_cnt", {16'd0, frame_cnt}, 32'd0);
        release_x();
        chk("nom_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("nom_rel_ready", {31'd0, s_ready}, 32'd1);
        chk("nom_rel_valid", {31'd0, x_valid}, 32'd0);

        // Back-to-back frames, x_ready tied high
        x_ready = 1'b1;
        c0 = cyc;
        send_frame(8'h40, IN, IN - 1, 1'b0);
        check_vec("b2b1_vec", 8'h40);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        tick();
        chk("b2b1_period", cyc - c0, 32'd129);
        c0 = cyc;
        send_frame(8'h80, IN, IN - 1, 1'b0);
        check_vec("b2b2_vec", 8'h80);
        s_valid = 1'b1;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("b2b2_period", cyc - c0, 32'd129);
        chk("b2b_cnt", {16'd0, frame_cnt}, 32'd3);
        x_ready = 1'b0;

        // Short frame: last on beat 50
        e0 = err_cnt;
        c0 = cyc;
        send_frame(8'h10, 51, 50, 1'b0);
        chk("short_err_hi", {31'd0, frame_err}, 32'd1);
        tick();
        chk("short_err_lo", {31'd0, frame_err}, 32'd0);
        chk("short_err_cnt", err_cnt - e0, 32'd1);
        chk("short_err_time", err_cyc - c0, 32'd51);
        chk("short_x_valid", {31'd0, x_valid}, 32'd0);
        send_frame(8'h20, IN, IN - 1, 1'b0);
        check_vec("short_next_vec", 8'h20);
        release_x();
        chk("short_next_cnt", {16'd0, frame_cnt}, 32'd4);

        // Long frame: 140 beats, last on beat 139
        e0 = err_cnt;
        c0 = cyc;
        send_frame(8'h30, 140, 139, 1'b0);
        tick();
        chk("long_err_cnt", err_cnt - e0, 32'd1);
        chk("long_err_time", err_cyc - c0, 32'd128);
        chk("long_x_valid", {31'd0, x_valid}, 32'd0);
        chk("long_drain_nowrite", {24'd0, x[0]}, 32'h30);
        send_frame(8'h50, IN, IN - 1, 1'b0);
        chk("long_next_x0", {24'd0, x[0]}, 32'h50);
        check_vec("long_next_vec", 8'h50);
        release_x();
        chk("long_next_cnt", {16'd0, frame_cnt}, 32'd5);

        // Bubbles with stray s_last on idle cycles
        e0 = err_cnt;
        send_frame(8'h60, IN, IN - 1, 1'b1);
        chk("bub_x_valid", {31'd0, x_valid}, 32'd1);
        check_vec("bub_vec", 8'h60);
        release_x();
        chk("bub_err_cnt", err_cnt - e0, 32'd0);
        chk("bub_cnt", {16'd0, frame_cnt}, 32'd6);

        // Async reset mid-frame after 60 beats
        e0 = err_cnt;
        send_frame(8'h70, 60, 1000, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("arst_mid_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("arst_mid_ready", {31'd0, s_ready}, 32'd1);
        chk("arst_mid_valid", {31'd0, x_valid}, 32'd0);
        chk("arst_mid_x0", {24'd0, x[0]}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h90, IN, IN - 1, 1'b0);
        check_vec("arst_mid_vec", 8'h90);
        release_x();
        chk("arst_mid_after_cnt", {16'd0, frame_cnt}, 32'd1);

        // Async reset while holding a vector
        send_frame(8'hA0, IN, IN - 1, 1'b0);
        chk("arst_hold_pre", {31'd0, x_valid}, 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_hold_valid", {31'd0, x_valid}, 32'd0);
        chk("arst_hold_ready", {31'd0, s_ready}, 32'd1);
        chk("arst_hold_cnt", {16'd0, frame_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'hB0, IN, IN - 1, 1'b0);
        check_vec("arst_hold_vec", 8'hB0);
        release_x();
        chk("arst_hold_after_cnt", {16'd0, frame_cnt}, 32'd1);
        chk("arst_no_err", err_cnt - e0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
